// File: rtl/branch_redirect_ctrl.sv
// Branch / R7 redirect controller: freezes fetch on a stall request, redirects the PC
// on a taken branch or R7 write-back, then drains. Optional perf counters: BRANCH_REDIRECT_PERF_EN.
module branch_redirect_ctrl #(
   parameter int PC_W         = 16,
   parameter int DRAIN_CYCLES = 2,
   parameter int HOLD_MAX     = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_in,
   input  logic            resolve_valid,
   input  logic            resolve_taken,
   input  logic [PC_W-1:0] resolve_target,
   input  logic            r7_wb_valid,
   input  logic [PC_W-1:0] r7_wb_data,
   input  logic [PC_W-1:0] pc_plus1,
   output logic            pc_we,
   output logic [PC_W-1:0] pc_next,
   output logic            if_id_we,
   output logic            flush_if_id,
   output logic            flush_id_rr,
   output logic            busy,
`ifdef BRANCH_REDIRECT_PERF_EN
   output logic [15:0]     stall_cycles,
   output logic [7:0]      redirect_count,
`endif
   output logic            hold_timeout
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_HOLD     = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_DRAIN    = 2'd3
   } state_t;

   localparam logic [2:0] LP_DRAIN    = 3'(DRAIN_CYCLES);
   localparam logic [7:0] LP_HOLD_MAX = 8'(HOLD_MAX);

   state_t          r_state;
   logic [PC_W-1:0] r_target;
   logic [2:0]      r_drainCnt;
   logic [7:0]      r_holdCnt;
   logic            r_holdTimeout;

   logic w_branchRedirect;
   assign w_branchRedirect = resolve_valid && resolve_taken;

   // R7 write-back is older than the branch in EX, so it wins when both fire.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_RUN;
         r_target      <= '0;
         r_drainCnt    <= '0;
         r_holdCnt     <= '0;
         r_holdTimeout <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (stall_in) begin
                  r_state   <= ST_HOLD;
                  r_holdCnt <= 8'd1;
               end
            end
            ST_HOLD: begin
               if (r7_wb_valid) begin
                  r_target <= r7_wb_data;
                  r_state  <= ST_REDIRECT;
               end else if (w_branchRedirect) begin
                  r_target <= resolve_target;
                  r_state  <= ST_REDIRECT;
               end else if (!stall_in) begin
                  r_state <= ST_RUN;
               end else if (r_holdCnt == LP_HOLD_MAX) begin
                  r_holdTimeout <= 1'b1;
                  r_state       <= ST_RUN;
               end else begin
                  r_holdCnt <= r_holdCnt + 8'd1;
               end
            end
            ST_REDIRECT: begin
               if (DRAIN_CYCLES > 0) begin
                  r_state    <= ST_DRAIN;
                  r_drainCnt <= LP_DRAIN;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (r7_wb_valid) begin
                  r_target <= r7_wb_data;
                  r_state  <= ST_REDIRECT;
               end else if (r_drainCnt <= 3'd1) begin
                  r_state <= ST_RUN;
               end else begin
                  r_drainCnt <= r_drainCnt - 3'd1;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   // Outputs are decoded combinationally so a stall freezes the PC in the same cycle.
   always_comb begin
      pc_we       = 1'b0;
      pc_next     = pc_plus1;
      if_id_we    = 1'b0;
      flush_if_id = 1'b0;
      flush_id_rr = 1'b0;
      busy        = 1'b0;
      if (reset) begin
         flush_if_id = 1'b1;
         flush_id_rr = 1'b1;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (stall_in) begin
                  flush_id_rr = 1'b1;
               end else begin
                  pc_we    = 1'b1;
                  if_id_we = 1'b1;
               end
            end
            ST_HOLD: begin
               flush_id_rr = 1'b1;
               busy        = 1'b1;
            end
            ST_REDIRECT: begin
               pc_we       = 1'b1;
               pc_next     = r_target;
               flush_if_id = 1'b1;
               flush_id_rr = 1'b1;
               busy        = 1'b1;
            end
            ST_DRAIN: begin
               pc_we    = 1'b1;
               if_id_we = 1'b1;
               busy     = 1'b1;
            end
            default: begin
               flush_if_id = 1'b1;
               flush_id_rr = 1'b1;
            end
         endcase
      end
   end

   assign hold_timeout = r_holdTimeout;

`ifdef BRANCH_REDIRECT_PERF_EN
   logic [15:0] r_stallCycles;
   logic [7:0]  r_redirectCount;

   // Busy-cycle count saturates; the redirect count is allowed to wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stallCycles   <= '0;
         r_redirectCount <= '0;
      end else begin
         if (busy && (r_stallCycles != 16'hFFFF)) begin
            r_stallCycles <= r_stallCycles + 16'd1;
         end
         if (r_state == ST_REDIRECT) begin
            r_redirectCount <= r_redirectCount + 8'd1;
         end
      end
   end

   assign stall_cycles   = r_stallCycles;
   assign redirect_count = r_redirectCount;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the redirect protocol.
module tb_branch_redirect_ctrl;

   localparam int PC_W         = 16;
   localparam int DRAIN_CYCLES = 2;
   localparam int HOLD_MAX     = 15;

   localparam int M_RUN   = 0;
   localparam int M_HOLD  = 1;
   localparam int M_REDIR = 2;
   localparam int M_DRAIN = 3;

   logic            clk;
   logic            reset;
   logic            stall_in;
   logic            resolve_valid;
   logic            resolve_taken;
   logic [PC_W-1:0] resolve_target;
   logic            r7_wb_valid;
   logic [PC_W-1:0] r7_wb_data;
   logic [PC_W-1:0] pc_plus1;
   logic            pc_we;
   logic [PC_W-1:0] pc_next;
   logic            if_id_we;
   logic            flush_if_id;
   logic            flush_id_rr;
   logic            busy;
   logic            hold_timeout;
`ifdef BRANCH_REDIRECT_PERF_EN
   logic [15:0]     stall_cycles;
   logic [7:0]      redirect_count;
`endif

   branch_redirect_ctrl #(
      .PC_W(PC_W), .DRAIN_CYCLES(DRAIN_CYCLES), .HOLD_MAX(HOLD_MAX)
   ) dut (
      .clk(clk), .reset(reset), .stall_in(stall_in),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .resolve_target(resolve_target), .r7_wb_valid(r7_wb_valid),
      .r7_wb_data(r7_wb_data), .pc_plus1(pc_plus1), .pc_we(pc_we),
      .pc_next(pc_next), .if_id_we(if_id_we), .flush_if_id(flush_if_id),
      .flush_id_rr(flush_id_rr), .busy(busy),
`ifdef BRANCH_REDIRECT_PERF_EN
      .stall_cycles(stall_cycles), .redirect_count(redirect_count),
`endif
      .hold_timeout(hold_timeout)
   );

   typedef struct packed {
      logic            pcWe;
      logic [PC_W-1:0] pcNext;
      logic            pcNextCare;
      logic            ifIdWe;
      logic            flushIfId;
      logic            flushIdRr;
      logic            busy;
      logic            holdTimeout;
      logic [15:0]     stallCycles;
      logic [7:0]      redirectCount;
   } exp_t;

   exp_t scoreQ[$];
   int   totalChecks = 0;
   int   badChecks   = 0;

   int              mMode       = M_RUN;
   logic [PC_W-1:0] mTarget     = '0;
   int              mHoldCycles = 0;
   int              mDrainLeft  = 0;
   bit              mTimeout    = 1'b0;
   int              mStallCycles = 0;
   int              mRedirects  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs this cycle, from the protocol rules for the current mode.
   function automatic exp_t expectNow();
      exp_t e;
      e = '0;
      e.pcNext        = pc_plus1;
      e.holdTimeout   = mTimeout;
      e.stallCycles   = 16'(mStallCycles);
      e.redirectCount = 8'(mRedirects);
      if (reset) begin
         e.flushIfId  = 1'b1;
         e.flushIdRr  = 1'b1;
         e.pcNextCare = 1'b1;
      end else if (mMode == M_RUN) begin
         e.pcWe      = !stall_in;
         e.ifIdWe    = !stall_in;
         e.flushIdRr = stall_in;
         e.pcNextCare = !stall_in;
      end else if (mMode == M_HOLD) begin
         e.flushIdRr = 1'b1;
         e.busy      = 1'b1;
      end else if (mMode == M_REDIR) begin
         e.pcWe       = 1'b1;
         e.pcNext     = mTarget;
         e.pcNextCare = 1'b1;
         e.flushIfId  = 1'b1;
         e.flushIdRr  = 1'b1;
         e.busy       = 1'b1;
      end else begin
         e.pcWe       = 1'b1;
         e.ifIdWe     = 1'b1;
         e.pcNextCare = 1'b1;
         e.busy       = 1'b1;
      end
      return e;
   endfunction

   // Advance the model by one clock edge using the inputs that were applied.
   task automatic modelStep();
      if (reset) begin
         mMode = M_RUN; mTarget = '0; mHoldCycles = 0; mDrainLeft = 0;
         mTimeout = 1'b0; mStallCycles = 0; mRedirects = 0;
      end else begin
         if (mMode != M_RUN && mStallCycles < 65535) mStallCycles++;
         if (mMode == M_REDIR) mRedirects = (mRedirects + 1) % 256;
         case (mMode)
            M_RUN: if (stall_in) begin mMode = M_HOLD; mHoldCycles = 1; end
            M_HOLD: begin
               if (r7_wb_valid) begin
                  mTarget = r7_wb_data; mMode = M_REDIR;
               end else if (resolve_valid && resolve_taken) begin
                  mTarget = resolve_target; mMode = M_REDIR;
               end else if (!stall_in) begin
                  mMode = M_RUN;
               end else if (mHoldCycles >= HOLD_MAX) begin
                  mTimeout = 1'b1; mMode = M_RUN;
               end else begin
                  mHoldCycles++;
               end
            end
            M_REDIR: begin
               mDrainLeft = DRAIN_CYCLES;
               mMode = (DRAIN_CYCLES > 0) ? M_DRAIN : M_RUN;
            end
            default: begin
               if (r7_wb_valid) begin
                  mTarget = r7_wb_data; mMode = M_REDIR;
               end else begin
                  mDrainLeft--;
                  if (mDrainLeft == 0) mMode = M_RUN;
               end
            end
         endcase
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit stall, input bit rv, input bit rt,
                                input logic [PC_W-1:0] rtgt, input bit r7v,
                                input logic [PC_W-1:0] r7d);
      @(negedge clk);
      reset          = rst;
      stall_in       = stall;
      resolve_valid  = rv;
      resolve_taken  = rt;
      resolve_target = rtgt;
      r7_wb_valid    = r7v;
      r7_wb_data     = r7d;
      pc_plus1       = PC_W'($urandom);
      scoreQ.push_back(expectNow());
      @(posedge clk);
      modelStep();
   endtask

   task automatic checkOutput(input exp_t e);
      totalChecks++;
      if ({pc_we, if_id_we, flush_if_id, flush_id_rr, busy} !==
          {e.pcWe, e.ifIdWe, e.flushIfId, e.flushIdRr, e.busy}) begin
         badChecks++;
         $display("[TB] FAIL ctrl t=%0t got we/ifid/fif/frr/busy=%b%b%b%b%b want %b%b%b%b%b", $time,
                  pc_we, if_id_we, flush_if_id, flush_id_rr, busy,
                  e.pcWe, e.ifIdWe, e.flushIfId, e.flushIdRr, e.busy);
      end
      if (e.pcNextCare) begin
         totalChecks++;
         if (pc_next !== e.pcNext) begin
            badChecks++;
            $display("[TB] FAIL pc_next t=%0t got %h want %h", $time, pc_next, e.pcNext);
         end
      end
      totalChecks++;
      if (hold_timeout !== e.holdTimeout) begin
         badChecks++;
         $display("[TB] FAIL hold_timeout t=%0t got %b want %b", $time, hold_timeout, e.holdTimeout);
      end
`ifdef BRANCH_REDIRECT_PERF_EN
      totalChecks++;
      if (stall_cycles !== e.stallCycles || redirect_count !== e.redirectCount) begin
         badChecks++;
         $display("[TB] FAIL perf t=%0t got stall=%0d redir=%0d want stall=%0d redir=%0d", $time,
                  stall_cycles, redirect_count, e.stallCycles, e.redirectCount);
      end
`endif
   endtask

   // Monitor: compares every presented cycle against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      reset = 1'b1; stall_in = 1'b1; resolve_valid = 1'b0; resolve_taken = 1'b0;
      resolve_target = '0; r7_wb_valid = 1'b0; r7_wb_data = '0; pc_plus1 = '0;

      // Reset held with stall asserted, then RUN -> HOLD.
      repeat (2) applyStimulus(1, 1, 0, 0, '0, 0, '0);
      repeat (3) applyStimulus(0, 1, 0, 0, '0, 0, '0);
      applyStimulus(0, 1, 1, 1, 16'h0040, 0, '0);
      repeat (3) applyStimulus(0, 1, 0, 0, '0, 0, '0);
      repeat (2) applyStimulus(0, 0, 0, 0, '0, 0, '0);

      // Not-taken resolve with stall released: straight back to RUN.
      repeat (2) applyStimulus(0, 1, 0, 0, '0, 0, '0);
      applyStimulus(0, 0, 1, 0, 16'h0077, 0, '0);
      repeat (2) applyStimulus(0, 0, 0, 0, '0, 0, '0);

      // R7 write-back beats a simultaneous taken branch.
      repeat (2) applyStimulus(0, 1, 0, 0, '0, 0, '0);
      applyStimulus(0, 1, 1, 1, 16'h0040, 1, 16'h1234);
      repeat (4) applyStimulus(0, 0, 0, 0, '0, 0, '0);

      // R7 write-back during DRAIN restarts the redirect.
      repeat (2) applyStimulus(0, 1, 0, 0, '0, 0, '0);
      applyStimulus(0, 1, 1, 1, 16'h0100, 0, '0);
      applyStimulus(0, 1, 0, 0, '0, 0, '0);
      applyStimulus(0, 1, 1, 1, 16'h0200, 1, 16'hBEEF);
      repeat (5) applyStimulus(0, 0, 0, 0, '0, 0, '0);

      // Watchdog: stall held well past HOLD_MAX.
      repeat (20) applyStimulus(0, 1, 0, 0, '0, 0, '0);
      repeat (2) applyStimulus(0, 0, 0, 0, '0, 0, '0);

      // Two five-busy-cycle redirect sequences after a reset.
      applyStimulus(1, 0, 0, 0, '0, 0, '0);
      repeat (2) begin
         repeat (2) applyStimulus(0, 1, 0, 0, '0, 0, '0);
         applyStimulus(0, 1, 1, 1, 16'h0800, 0, '0);
         repeat (3) applyStimulus(0, 0, 0, 0, '0, 0, '0);
      end
      applyStimulus(1, 0, 0, 0, '0, 0, '0);

      // Busy random traffic.
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(99) == 0, $urandom_range(9) < 7,
                       $urandom_range(9) < 2, $urandom_range(1) == 1, PC_W'($urandom),
                       $urandom_range(9) == 0, PC_W'($urandom));
      end
      // Sparse events so long holds reach the watchdog.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(199) == 0, $urandom_range(19) != 0,
                       $urandom_range(49) == 0, $urandom_range(1) == 1, PC_W'($urandom),
                       $urandom_range(49) == 0, PC_W'($urandom));
      end

      repeat (3) @(negedge clk);
      totalChecks++;
      if (scoreQ.size() != 0) begin
         badChecks++;
         $display("[TB] FAIL drain_queue got %0d pending want 0", scoreQ.size());
      end
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
